// File: rtl/motor_startup_sequencer.sv
// Startup sequencer for a sensored BLDC drive: IDLE -> ALIGN -> SETTLE -> RUN, with stall
// detection into a latched FAULT. All outputs are registered and decoded from the next state.
module motor_startup_sequencer #(
    parameter int unsigned ALIGN_CYCLES  = 1000000,
    parameter int unsigned SETTLE_CYCLES = 250000,
    parameter int unsigned FILTER_DIV    = 500,
    parameter int unsigned CONTROL_DIV   = 5000,
    parameter int unsigned STALL_CYCLES  = 2000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       fault_clear,
    input  logic       encoder_change,
    output logic       reset_encoder_count,
    output logic       apply_initial_commutation,
    output logic       controller_override,
    output logic       commutation_enable,
    output logic       filter_pulse,
    output logic       control_loop_pulse,
    output logic       fault,
    output logic [2:0] state
);

    localparam logic [31:0] AlignN  = 32'(ALIGN_CYCLES);
    localparam logic [31:0] SettleN = 32'(SETTLE_CYCLES);
    localparam logic [31:0] FiltN   = 32'(FILTER_DIV);
    localparam logic [31:0] CtrlN   = 32'(CONTROL_DIV);
    localparam logic [31:0] StallN  = 32'(STALL_CYCLES);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StAlign  = 3'd1,
        StSettle = 3'd2,
        StRun    = 3'd3,
        StFault  = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] phase_q, phase_d;
    logic [31:0] filt_q, filt_d;
    logic [31:0] ctrl_q, ctrl_d;
    logic [31:0] stall_q, stall_d;
    logic        stall_hit, entering;
    logic        rec_d, aic_d, co_d, ce_d, fp_d, cp_d, fault_d;

    assign state = state_q;

    always_comb begin
        stall_hit = (state_q == StRun) && !encoder_change && (stall_q == StallN - 32'd1);
        state_d   = state_q;
        case (state_q)
            StIdle:   if (enable) state_d = StAlign;
            StAlign: begin
                if (!enable)                 state_d = StIdle;
                else if (phase_q == AlignN)  state_d = StSettle;
            end
            StSettle: begin
                if (!enable)                 state_d = StIdle;
                else if (phase_q == SettleN) state_d = StRun;
            end
            // Stall has priority over a simultaneous enable drop
            StRun: begin
                if (stall_hit)               state_d = StFault;
                else if (!enable)            state_d = StIdle;
            end
            StFault:  if (fault_clear && !enable) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Counters hold the count for the cycle they are registered into (1-based)
    always_comb begin
        entering = (state_d != state_q);

        phase_d = 32'd0;
        if (state_d == StAlign || state_d == StSettle)
            phase_d = entering ? 32'd1 : phase_q + 32'd1;

        filt_d = 32'd0;
        if (state_d == StSettle && entering)
            filt_d = 32'd1;
        else if (state_d == StSettle || state_d == StRun)
            filt_d = (filt_q >= FiltN) ? 32'd1 : filt_q + 32'd1;

        ctrl_d = 32'd0;
        if (state_d == StRun)
            ctrl_d = (entering || ctrl_q >= CtrlN) ? 32'd1 : ctrl_q + 32'd1;

        stall_d = 32'd0;
        if (state_d == StRun && !entering && !encoder_change)
            stall_d = (stall_q == 32'hFFFF_FFFF) ? stall_q : stall_q + 32'd1;

        rec_d   = (state_d == StSettle) && entering;
        aic_d   = (state_d == StAlign);
        co_d    = (state_d == StAlign) || (state_d == StSettle);
        ce_d    = (state_d == StAlign) || (state_d == StSettle) || (state_d == StRun);
        fp_d    = ((state_d == StSettle) || (state_d == StRun)) && (filt_d == FiltN);
        cp_d    = (state_d == StRun) && (ctrl_d == CtrlN);
        fault_d = (state_d == StFault);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q                   <= StIdle;
            phase_q                   <= 32'd0;
            filt_q                    <= 32'd0;
            ctrl_q                    <= 32'd0;
            stall_q                   <= 32'd0;
            reset_encoder_count       <= 1'b0;
            apply_initial_commutation <= 1'b0;
            controller_override       <= 1'b0;
            commutation_enable        <= 1'b0;
            filter_pulse              <= 1'b0;
            control_loop_pulse        <= 1'b0;
            fault                     <= 1'b0;
        end else begin
            state_q                   <= state_d;
            phase_q                   <= phase_d;
            filt_q                    <= filt_d;
            ctrl_q                    <= ctrl_d;
            stall_q                   <= stall_d;
            reset_encoder_count       <= rec_d;
            apply_initial_commutation <= aic_d;
            controller_override       <= co_d;
            commutation_enable        <= ce_d;
            filter_pulse              <= fp_d;
            control_loop_pulse        <= cp_d;
            fault                     <= fault_d;
        end
    end

endmodule
